// File: rtl/bz_sfx_sequencer.sv
// bz_sfx_sequencer: sound-effect sequencer in front of the buzzer music player.
// Captures one-cycle game events into a pending register, queues them highest
// index first through a small FIFO, and plays one clip at a time with a silent
// gap between clips.
// Optional feature: define BZ_SFX_PREEMPT_EN so that the top-index event
// (the crash clip) preempts a clip that is playing.
module bz_sfx_sequencer #(
   parameter int unsigned N_EVT   = 3,
   parameter int unsigned SEL_W   = 2,
   parameter int unsigned QDEPTH  = 4,
   parameter int unsigned GAP_CYC = 50000,
   parameter int unsigned MAX_CYC = 2**26
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_EVT-1:0] evt,
   input  logic             play_finish,
   output logic             music_en,
   output logic [SEL_W-1:0] song_sel,
   output logic             busy,
   output logic             timeout,
   output logic [7:0]       drop_cnt
);

   localparam int unsigned PTR_W   = $clog2(QDEPTH);
   localparam int unsigned CNTQ_W  = PTR_W + 1;
   localparam int unsigned CNT_MAX = (MAX_CYC > GAP_CYC) ? MAX_CYC : GAP_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PLAY = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [N_EVT-1:0]   r_pending;
   logic [N_EVT-1:0]   w_pending_nxt;
   logic [N_EVT-1:0]   w_clr_mask;
   logic [SEL_W-1:0]   r_mem [QDEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNTQ_W-1:0]  r_count;
   logic [SEL_W-1:0]   r_song_sel;
   logic               r_music_en;
   logic               r_busy;
   logic               r_timeout;
   logic [7:0]         r_drop_cnt;
   logic [SEL_W-1:0]   w_top_idx;
   logic               w_top_vld;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic               w_tmo;
   logic               w_preempt;

   assign music_en = r_music_en;
   assign song_sel = r_song_sel;
   assign busy     = r_busy;
   assign timeout  = r_timeout;
   assign drop_cnt = r_drop_cnt;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNTQ_W'(QDEPTH));

   // Priority encoder: highest set pending bit is the next push candidate
   always_comb begin
      w_top_idx = '0;
      w_top_vld = 1'b0;
      for (int unsigned i = 0; i < N_EVT; i++) begin
         if (r_pending[i]) begin
            w_top_idx = SEL_W'(i);
            w_top_vld = 1'b1;
         end
      end
   end

   // Crash event interrupts a playing clip unless the crash clip is already playing
`ifdef BZ_SFX_PREEMPT_EN
   always_comb begin
      w_preempt = (r_state == S_PLAY) && evt[N_EVT-1] &&
                  (r_song_sel != SEL_W'(N_EVT-1));
   end
`else
   always_comb begin
      w_preempt = 1'b0;
   end
`endif

   // Push/drop decision and next pending vector; a same-cycle pop frees a full slot
   always_comb begin
      w_clr_mask    = '0;
      w_push        = 1'b0;
      w_drop        = 1'b0;
      w_pending_nxt = r_pending | evt;
      if (w_top_vld) begin
         w_clr_mask = N_EVT'(1) << w_top_idx;
         w_push     = !w_full || w_pop;
         w_drop     = w_full && !w_pop;
      end
      if (w_preempt) begin
         w_push        = 1'b0;
         w_drop        = 1'b0;
         w_pending_nxt = '0;
      end else begin
         w_pending_nxt = (r_pending & ~w_clr_mask) | evt;
      end
   end

   // Next-state logic for the playback FSM
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_PLAY;
         end
         S_PLAY: begin
            if (r_cnt == CNT_W'(MAX_CYC - 1)) begin
               w_tmo       = 1'b1;
               w_state_nxt = S_GAP;
            end else if (play_finish && (r_cnt >= CNT_W'(2))) begin
               w_state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (w_preempt) begin
         w_tmo       = 1'b0;
         w_state_nxt = S_LOAD;
      end
   end

   // FSM state, per-state cycle counter and registered player-facing outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_song_sel <= '0;
         r_music_en <= 1'b0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_music_en <= (w_state_nxt == S_PLAY);
         r_busy     <= (w_state_nxt != S_IDLE);
         r_timeout  <= w_tmo;
         if (w_state_nxt != r_state) begin
            r_cnt <= '0;
         end else if ((r_state == S_PLAY) || (r_state == S_GAP)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_preempt) begin
            r_song_sel <= SEL_W'(N_EVT - 1);
         end else if (w_pop) begin
            r_song_sel <= r_mem[r_rptr];
         end
      end
   end

   // Pending capture, FIFO pointers/occupancy and saturating drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending  <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_preempt) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
               r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNTQ_W'(w_push) - CNTQ_W'(w_pop);
         end
         if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   // FIFO storage; contents are qualified by the pointers so no reset is needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_top_idx;
      end
   end

endmodule
